// File: rtl/ps2_mouse_rx.sv
`timescale 1ns/1ps
// ps2_mouse_rx: receive-only PS/2 mouse front end.
// Deserialises device-driven PS2_CLK/PS2_DAT into 11-bit frames and assembles
// 3-byte stream-mode movement packets into registered dx/dy/button outputs.
// Ports:
//   Clk, Reset_n          - system clock, async active-low reset
//   PS2_CLK, PS2_DAT      - raw PS/2 lines, asynchronous to Clk
//   new_data              - one-cycle strobe, packet committed
//   dx, dy                - 9-bit two's-complement movement, saturated on overflow
//   m1, m2, m3            - left / right / middle buttons
//   frame_err             - one-cycle strobe on any dropped frame or packet
module ps2_mouse_rx #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic       new_data,
  output logic [8:0] dx,
  output logic [8:0] dy,
  output logic       m1,
  output logic       m2,
  output logic       m3,
  output logic       frame_err
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
  logic               clk_sync_s, dat_sync_s;
  logic [FCW-1:0]     flt_cnt_q, flt_cnt_d;
  logic               flt_clk_q, flt_clk_d, flt_prev_q;
  logic               bit_evt_q, bit_dat_q;
  logic [2:0]         bit_cnt_q;
  logic [7:0]         shift_q, b0_q, b1_q;
  logic               par_q;
  logic [1:0]         idx_q;
  logic [WDW-1:0]     wd_q;
  logic               new_data_q, frame_err_q, m1_q, m2_q, m3_q;
  logic [8:0]         dx_q, dy_q;
  logic               stop_s, byte_ok_s, byte_bad_s, sync_bad_s, commit_s;
  logic               wd_active_s, wd_expire_s, err_s;

  // Overflow saturation: a set overflow flag pins the value to the extreme of its sign.
  function automatic logic [8:0] sat9(input logic ovf, input logic sgn, input logic [7:0] mag);
    if (ovf) begin
      sat9 = sgn ? 9'h100 : 9'h0FF;
    end else begin
      sat9 = {sgn, mag};
    end
  endfunction

  // Odd parity over data plus parity bit.
  function automatic logic odd_par_ok(input logic [7:0] data, input logic par);
    odd_par_ok = ^{data, par};
  endfunction

  assign clk_sync_s = clk_sync_q[SYNC_STAGES-1];
  assign dat_sync_s = dat_sync_q[SYNC_STAGES-1];

  // Synchronisers; idle bus level is high so reset to ones.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], PS2_CLK};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], PS2_DAT};
    end
  end

  // Glitch filter: level follows only after FILTER_LEN consecutive differing samples.
  always_comb begin
    flt_clk_d = flt_clk_q;
    flt_cnt_d = '0;
    if (clk_sync_s == flt_clk_q) begin
      flt_cnt_d = '0;
    end else if (flt_cnt_q == FCW'(FILTER_LEN - 1)) begin
      flt_clk_d = clk_sync_s;
      flt_cnt_d = '0;
    end else begin
      flt_cnt_d = flt_cnt_q + FCW'(1);
    end
  end

  // Filter state plus registered falling-edge bit event with its data sample.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      flt_cnt_q  <= '0;
      flt_clk_q  <= 1'b1;
      flt_prev_q <= 1'b1;
      bit_evt_q  <= 1'b0;
      bit_dat_q  <= 1'b1;
    end else begin
      flt_cnt_q  <= flt_cnt_d;
      flt_clk_q  <= flt_clk_d;
      flt_prev_q <= flt_clk_q;
      bit_evt_q  <= flt_prev_q & ~flt_clk_q;
      bit_dat_q  <= dat_sync_s;
    end
  end

  // Frame FSM state register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Frame FSM next state; a bit event takes priority over watchdog expiry.
  always_comb begin
    state_d = state_q;
    if (bit_evt_q) begin
      case (state_q)
        S_IDLE:   state_d = bit_dat_q ? S_IDLE : S_DATA;
        S_DATA:   state_d = (bit_cnt_q == 3'd7) ? S_PARITY : S_DATA;
        S_PARITY: state_d = S_STOP;
        S_STOP:   state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end else if (wd_expire_s) begin
      state_d = S_IDLE;
    end else begin
      state_d = state_q;
    end
  end

  // Frame FSM outputs: byte verdicts and error/commit decisions.
  always_comb begin
    stop_s      = bit_evt_q && (state_q == S_STOP);
    byte_ok_s   = stop_s && odd_par_ok(shift_q, par_q) && bit_dat_q;
    byte_bad_s  = stop_s && !byte_ok_s;
    sync_bad_s  = byte_ok_s && (idx_q == 2'd0) && !shift_q[3];
    commit_s    = byte_ok_s && (idx_q == 2'd2);
    wd_active_s = (state_q != S_IDLE) || (idx_q != 2'd0);
    wd_expire_s = !bit_evt_q && wd_active_s && (wd_q == WDW'(TIMEOUT_CYCLES - 1));
    err_s       = byte_bad_s || sync_bad_s || wd_expire_s;
  end

  // Frame datapath, packet byte index, and watchdog counter.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      par_q     <= 1'b0;
      idx_q     <= 2'd0;
      b0_q      <= 8'h00;
      b1_q      <= 8'h00;
      wd_q      <= '0;
    end else begin
      if (bit_evt_q && (state_q == S_IDLE)) begin
        bit_cnt_q <= 3'd0;
      end else if (bit_evt_q && (state_q == S_DATA)) begin
        bit_cnt_q <= bit_cnt_q + 3'd1;
        shift_q   <= {bit_dat_q, shift_q[7:1]};
      end else if (bit_evt_q && (state_q == S_PARITY)) begin
        par_q <= bit_dat_q;
      end else begin
        bit_cnt_q <= bit_cnt_q;
      end

      if (wd_expire_s || byte_bad_s || sync_bad_s || commit_s) begin
        idx_q <= 2'd0;
      end else if (byte_ok_s) begin
        idx_q <= idx_q + 2'd1;
        if (idx_q == 2'd0) begin
          b0_q <= shift_q;
        end else begin
          b1_q <= shift_q;
        end
      end else begin
        idx_q <= idx_q;
      end

      if (bit_evt_q || wd_expire_s || !wd_active_s) begin
        wd_q <= '0;
      end else begin
        wd_q <= wd_q + WDW'(1);
      end
    end
  end

  // Registered outputs; movement/buttons change only on commit.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      new_data_q  <= 1'b0;
      frame_err_q <= 1'b0;
      dx_q        <= 9'h000;
      dy_q        <= 9'h000;
      m1_q        <= 1'b0;
      m2_q        <= 1'b0;
      m3_q        <= 1'b0;
    end else begin
      frame_err_q <= err_s;
      new_data_q  <= commit_s;
      if (commit_s) begin
        dx_q <= sat9(b0_q[6], b0_q[4], b1_q);
        dy_q <= sat9(b0_q[7], b0_q[5], shift_q);
        m1_q <= b0_q[0];
        m2_q <= b0_q[1];
        m3_q <= b0_q[2];
      end else begin
        dx_q <= dx_q;
      end
    end
  end

  assign new_data  = new_data_q;
  assign frame_err = frame_err_q;
  assign dx        = dx_q;
  assign dy        = dy_q;
  assign m1        = m1_q;
  assign m2        = m2_q;
  assign m3        = m3_q;

endmodule

// File: tb/tb_ps2_mouse_rx.sv
`timescale 1ns/1ps
module tb_ps2_mouse_rx;
  localparam int TO   = 2000;
  localparam int HALF = 40;
  localparam int LAT  = 12;

  typedef struct {
    bit         is_err;
    bit         chk_lat;
    logic [8:0] dx;
    logic [8:0] dy;
    logic       m1, m2, m3;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n, ps2_clk, ps2_dat;
  logic       new_data, frame_err, m1, m2, m3;
  logic [8:0] dx, dy;

  exp_t  q[$];
  exp_t  e;
  int    tests = 0;
  int    fails = 0;
  int    cyc = 0;
  int    stop_cyc = 0;
  int    hold_viol = 0;
  logic [20:0] prev_out = 21'h0;

  ps2_mouse_rx #(.SYNC_STAGES(2), .FILTER_LEN(8), .TIMEOUT_CYCLES(TO)) dut (
    .Clk(clk), .Reset_n(rst_n), .PS2_CLK(ps2_clk), .PS2_DAT(ps2_dat),
    .new_data(new_data), .dx(dx), .dy(dy), .m1(m1), .m2(m2), .m3(m3),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ps2_bit(input logic v, input bit glitch, input bit is_stop);
    ps2_dat = v;
    tick(15);
    if (glitch) begin
      ps2_clk = 1'b0;
      tick(3);
      ps2_clk = 1'b1;
      tick(HALF - 18);
    end else begin
      tick(HALF - 15);
    end
    ps2_clk = 1'b0;
    if (is_stop) stop_cyc = cyc;
    tick(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit glitch);
    logic par;
    par = (~^b) ^ bad_par;
    ps2_bit(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], glitch && (i == 4), 1'b0);
    ps2_bit(par, 1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0, 1'b1);
    tick(100);
  endtask

  task automatic expect_err(input bit lat);
    exp_t x;
    x.is_err = 1'b1; x.chk_lat = lat;
    x.dx = 9'h0; x.dy = 9'h0; x.m1 = 1'b0; x.m2 = 1'b0; x.m3 = 1'b0;
    q.push_back(x);
  endtask

  task automatic expect_pkt(input logic [8:0] edx, input logic [8:0] edy,
                            input logic em1, input logic em2, input logic em3);
    exp_t x;
    x.is_err = 1'b0; x.chk_lat = 1'b1;
    x.dx = edx; x.dy = edy; x.m1 = em1; x.m2 = em2; x.m3 = em3;
    q.push_back(x);
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                          input bit glitch);
    send_byte(b0, 1'b0, glitch);
    send_byte(b1, 1'b0, glitch);
    send_byte(b2, 1'b0, glitch);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_new_data"},  32'(new_data),  32'd0);
    chk({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    chk({tag, "_dx"},        32'(dx),        32'd0);
    chk({tag, "_dy"},        32'(dy),        32'd0);
    chk({tag, "_m1"},        32'(m1),        32'd0);
    chk({tag, "_m2"},        32'(m2),        32'd0);
    chk({tag, "_m3"},        32'(m3),        32'd0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT strobes, and watches hold behaviour.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (new_data || frame_err) begin
        chk("strobe_exclusive", 32'(new_data && frame_err), 32'd0);
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_strobe: got new_data=%0b frame_err=%0b expected none",
                   new_data, frame_err);
        end else begin
          e = q.pop_front();
          chk("strobe_kind", 32'(frame_err), 32'(e.is_err));
          if (e.chk_lat) chk("latency", 32'(cyc - stop_cyc), 32'(LAT));
          if (!e.is_err) begin
            chk("dx", 32'(dx), 32'(e.dx));
            chk("dy", 32'(dy), 32'(e.dy));
            chk("buttons", 32'({m3, m2, m1}), 32'({e.m3, e.m2, e.m1}));
          end
        end
      end
      if (!new_data && ({dx, dy, m1, m2, m3} != prev_out)) hold_viol <= hold_viol + 1;
    end
    prev_out <= {dx, dy, m1, m2, m3};
  end

  initial begin
    rst_n   = 1'b0;
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    tick(3);
    chk_zero_outputs("reset");
    @(posedge clk); #2 rst_n = 1'b1;
    tick(20);

    // Stray clock pulse with data high while idle: noise, no strobe.
    ps2_dat = 1'b1;
    ps2_clk = 1'b0;
    tick(HALF);
    ps2_clk = 1'b1;
    tick(100);

    // Nominal packet.
    expect_pkt(9'h005, 9'h1FB, 1'b1, 1'b0, 1'b0);
    send_pkt(8'h29, 8'h05, 8'hFB, 1'b0);

    // Parity error on byte1; the following 0x20 lacks bit3 and is a resync drop too.
    send_byte(8'h08, 1'b0, 1'b0);
    expect_err(1'b1);
    send_byte(8'h10, 1'b1, 1'b0);
    expect_err(1'b1);
    send_byte(8'h20, 1'b0, 1'b0);
    expect_pkt(9'h001, 9'h002, 1'b0, 1'b1, 1'b0);
    send_pkt(8'h0A, 8'h01, 8'h02, 1'b0);

    // Resync on byte0 without bit3.
    expect_err(1'b1);
    send_byte(8'h05, 1'b0, 1'b0);
    expect_pkt(9'h003, 9'h004, 1'b0, 1'b0, 1'b0);
    send_pkt(8'h08, 8'h03, 8'h04, 1'b0);

    // Watchdog: byte0 only, then stall past the timeout.
    send_byte(8'h08, 1'b0, 1'b0);
    expect_err(1'b0);
    tick(TO + 10);
    // Full packet with short clock glitches mid-frame.
    expect_pkt(9'h07F, 9'h080, 1'b1, 1'b0, 1'b0);
    send_pkt(8'h09, 8'h7F, 8'h80, 1'b1);

    // Overflow saturation cases.
    expect_pkt(9'h100, 9'h034, 1'b0, 1'b0, 1'b0);
    send_pkt(8'h58, 8'h12, 8'h34, 1'b0);
    expect_pkt(9'h056, 9'h0FF, 1'b0, 1'b0, 1'b0);
    send_pkt(8'h88, 8'h56, 8'h9A, 1'b0);
    expect_pkt(9'h0FF, 9'h100, 1'b0, 1'b0, 1'b0);
    send_pkt(8'hE8, 8'h00, 8'h00, 1'b0);

    // Reset after byte1, then a fresh packet.
    send_byte(8'h09, 1'b0, 1'b0);
    send_byte(8'h11, 1'b0, 1'b0);
    @(posedge clk); #2 rst_n = 1'b0;
    tick(2);
    chk_zero_outputs("midreset");
    tick(5);
    @(posedge clk); #2 rst_n = 1'b1;
    tick(50);
    expect_pkt(9'h022, 9'h033, 1'b0, 1'b0, 1'b1);
    send_pkt(8'h0C, 8'h22, 8'h33, 1'b0);

    // Drain: bounded wait for outstanding expectations.
    for (int i = 0; i < 200 && q.size() != 0; i++) tick(1);
    chk("queue_drained", 32'(q.size()), 32'd0);
    tick(5);
    chk("hold_between_commits", 32'(hold_viol), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
